axis_length_trim: RTL and testbench

Receive-side counterpart of the stream length-fill padder: takes an AXI-stream frame that may carry fill beats past its meaningful length and cuts it back to `length` beats. Beats past the limit are consumed and discarded, and `tlast` is forced on the last kept beat. Frames shorter than `length` pass through untouched. The block sits on the RX path directly before payload consumers, and has a registered output stage for full throughput.

---
 rtl/axis_length_trim_pkg.sv | 19 +
 rtl/axis_length_trim_skid.sv | 59 +++++
 rtl/axis_length_trim.sv | 127 ++++++++++++
 tb/tb_axis_length_trim.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/axis_length_trim_pkg.sv
// Shared types for the RX length trimmer.
// FSM encoding, counter width, saturating increment.
package DataInterfacePkg;

  localparam int LEN_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2
  } trim_state_t;

  function automatic logic [LEN_W-1:0] sat_inc(
    input logic [LEN_W-1:0] v
  );
    return (v == '1) ? v : v + LEN_W'(1);
  endfunction

endpackage

// File: rtl/axis_length_trim_skid.sv
// Two-entry register slice for {data, user, last}.
// Registered ready: high while the skid slot is free.
module axis_trim_skid
  import DataInterfacePkg::*;
#(
  parameter int W = 34
) (
  input  logic         clock,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [W-1:0] skid_d;
  logic         skid_v;
  logic         skid_v_n;
  logic         load;
  logic         push;

  assign load = !out_valid || out_ready;
  assign push = in_valid && in_ready;

  // Skid slot fills only when the output register is held.
  always_comb begin
    skid_v_n = skid_v;
    if (load) skid_v_n = 1'b0;
    else if (push) skid_v_n = 1'b1;
  end

  // Output register refills from skid first, then from input.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      skid_d    <= '0;
      skid_v    <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      in_ready <= !skid_v_n;
      skid_v   <= skid_v_n;
      if (load) begin
        if (skid_v) begin
          out_data  <= skid_d;
          out_valid <= 1'b1;
        end else begin
          out_valid <= push;
          if (push) out_data <= in_data;
        end
      end else if (push) begin
        skid_d <= in_data;
      end
    end
  end

endmodule

// File: rtl/axis_length_trim.sv
// Cuts AXI-stream frames back to a per-frame beat limit.
// Excess beats are swallowed; tlast forced on the last kept beat.
module axis_length_trim
  import DataInterfacePkg::*;
#(
  parameter int DSIZE = 32,
  parameter int USIZE = 1
) (
  input  logic               clock,
  input  logic               rst,
  input  logic [LEN_W-1:0]   length,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  input  logic               s_axis_tlast,
  input  logic [DSIZE-1:0]   s_axis_tdata,
  input  logic [USIZE-1:0]   s_axis_tuser,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               m_axis_tlast,
  output logic [DSIZE-1:0]   m_axis_tdata,
  output logic [USIZE-1:0]   m_axis_tuser,
  output logic [DSIZE/8-1:0] m_axis_tkeep,
  output logic               trim_flag,
  output logic [LEN_W-1:0]   trim_beats
);

  localparam int W = DSIZE + USIZE + 1;

  trim_state_t      state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] drop_cnt;
  logic [LEN_W:0]   cnt_nx;
  logic             at_lim;
  logic             skid_rdy;
  logic             acc;
  logic             fwd;
  logic             out_last;

  assign m_axis_tkeep  = '1;
  assign s_axis_tready = (state == DROP) || skid_rdy;
  assign acc    = s_axis_tvalid && s_axis_tready;
  assign cnt_nx = {1'b0, cnt} + (LEN_W+1)'(1);
  assign at_lim = (cnt_nx == {1'b0, len_q});

  // Which accepted beats reach the skid, and their tlast.
  always_comb begin
    fwd      = 1'b0;
    out_last = s_axis_tlast;
    unique case (state)
      IDLE: begin
        fwd      = acc && (length != '0);
        out_last = s_axis_tlast || (length == LEN_W'(1));
      end
      PASS: begin
        fwd      = acc;
        out_last = s_axis_tlast || at_lim;
      end
      default: ;
    endcase
  end

  // Frame FSM, beat counters and trim status.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      len_q      <= '0;
      cnt        <= '0;
      drop_cnt   <= '0;
      trim_flag  <= 1'b0;
      trim_beats <= '0;
    end else begin
      trim_flag <= 1'b0;
      if (acc) begin
        unique case (state)
          IDLE: begin
            len_q    <= length;
            cnt      <= LEN_W'(1);
            drop_cnt <= (length == '0) ? LEN_W'(1) : '0;
            if (s_axis_tlast) begin
              state      <= IDLE;
              trim_beats <= (length == '0) ? LEN_W'(1) : '0;
              trim_flag  <= (length == '0);
            end else if (length <= LEN_W'(1)) begin
              state <= DROP;
            end else begin
              state <= PASS;
            end
          end
          PASS: begin
            cnt <= sat_inc(cnt);
            if (s_axis_tlast) begin
              state      <= IDLE;
              trim_beats <= '0;
            end else if (at_lim) begin
              state    <= DROP;
              drop_cnt <= '0;
            end
          end
          DROP: begin
            drop_cnt <= sat_inc(drop_cnt);
            if (s_axis_tlast) begin
              state      <= IDLE;
              trim_beats <= sat_inc(drop_cnt);
              trim_flag  <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  axis_trim_skid #(
    .W(W)
  ) u_skid (
    .clock     (clock),
    .rst       (rst),
    .in_data   ({s_axis_tdata, s_axis_tuser, out_last}),
    .in_valid  (fwd),
    .in_ready  (skid_rdy),
    .out_data  ({m_axis_tdata, m_axis_tuser, m_axis_tlast}),
    .out_valid (m_axis_tvalid),
    .out_ready (m_axis_tready)
  );

endmodule

// File: tb/tb_axis_length_trim.sv
// Randomized self-checking bench for axis_length_trim.
// Frame-level reference model: kept = min(n, length).
module tb_axis_length_trim;

  logic        clock = 1'b0;
  logic        rst   = 1'b1;
  logic [15:0] length = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        s_tlast = 1'b0;
  logic [31:0] s_tdata = '0;
  logic [0:0]  s_tuser = '0;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic        m_tlast;
  logic [31:0] m_tdata;
  logic [0:0]  m_tuser;
  logic [3:0]  m_tkeep;
  logic        trim_flag;
  logic [15:0] trim_beats;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int rdy_mode = 0;

  logic [33:0] exp_q[$];
  int          out_t[$];

  always #5 clock = ~clock;

  axis_length_trim dut (
    .clock         (clock),
    .rst           (rst),
    .length        (length),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tlast  (s_tlast),
    .s_axis_tdata  (s_tdata),
    .s_axis_tuser  (s_tuser),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast),
    .m_axis_tdata  (m_tdata),
    .m_axis_tuser  (m_tuser),
    .m_axis_tkeep  (m_tkeep),
    .trim_flag     (trim_flag),
    .trim_beats    (trim_beats)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clock) begin
    cyc++;
    #1;
    unique case (rdy_mode)
      1: m_tready = ($urandom % 2) == 1;
      2: m_tready = 1'b0;
      default: m_tready = 1'b1;
    endcase
  end

  always @(negedge clock) begin
    if (!rst && m_tvalid && m_tready) begin
      out_t.push_back(cyc);
      if (exp_q.size() == 0)
        check("extra_beat", 64'(exp_q.size()), 64'd1);
      else
        check("beat", {30'd0, m_tlast, m_tuser, m_tdata},
              {30'd0, exp_q.pop_front()});
    end
  end

  task automatic send_beat(input logic [31:0] d,
                           input logic u,
                           input logic l,
                           input int gap);
    int t;
    s_tvalid = 1'b0;
    repeat (gap) begin
      @(posedge clock);
      #1;
    end
    s_tdata  = d;
    s_tuser  = u;
    s_tlast  = l;
    s_tvalid = 1'b1;
    t = 0;
    forever begin
      @(negedge clock);
      if (s_tready) break;
      t++;
      if (t > 500) begin
        check("in_timeout", 64'(t), 64'd0);
        break;
      end
    end
    @(posedge clock);
    #1;
    s_tvalid = 1'b0;
  endtask

  task automatic send_frame(input int n, input int len, input bit gaps);
    logic [31:0] da[40];
    logic        ua[40];
    int kept;
    int trim;
    int g;
    kept = (n < len) ? n : len;
    trim = n - kept;
    for (int i = 0; i < n; i++) begin
      da[i] = $urandom;
      ua[i] = $urandom % 2;
      if (i < kept)
        exp_q.push_back({i == kept - 1, ua[i], da[i]});
    end
    length = 16'(len);
    for (int i = 0; i < n; i++) begin
      g = 0;
      if (gaps && ($urandom % 4 == 0)) g = 1 + $urandom % 3;
      send_beat(da[i], ua[i], i == n - 1, g);
      if (i == 0) length = 16'($urandom);
    end
    check("trim_flag", 64'(trim_flag), 64'(trim > 0));
    check("trim_beats", 64'(trim_beats), 64'(trim));
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() > 0 && t < 3000) begin
      @(posedge clock);
      t++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
    repeat (5) @(posedge clock);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    #23;
    check("rst_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_tready", 64'(s_tready), 64'd0);
    check("rst_tdata", 64'(m_tdata), 64'd0);
    check("rst_tbeats", 64'(trim_beats), 64'd0);
    check("tkeep", 64'(m_tkeep), 64'hF);
    @(negedge clock);
    rst = 1'b0;
    @(posedge clock);
    #1;
    check("rdy_after_rst", 64'(s_tready), 64'd1);

    send_frame(6, 4, 1'b0);
    send_frame(3, 8, 1'b0);
    drain();

    out_t.delete();
    send_frame(4, 4, 1'b0);
    send_frame(1, 1, 1'b0);
    drain();
    check("b2b_count", 64'(out_t.size()), 64'd5);
    if (out_t.size() == 5)
      check("b2b_span", 64'(out_t[4] - out_t[0]), 64'd4);

    send_frame(5, 0, 1'b0);
    drain();

    rdy_mode = 1;
    for (int f = 0; f < 200; f++)
      send_frame(1 + $urandom % 40, $urandom % 33, 1'b1);
    drain();

    rdy_mode = 2;
    @(posedge clock);
    #1;
    length = 16'd2;
    exp_q.push_back({1'b0, 1'b0, 32'hA0});
    exp_q.push_back({1'b1, 1'b1, 32'hA1});
    send_beat(32'hA0, 1'b0, 1'b0, 0);
    send_beat(32'hA1, 1'b1, 1'b0, 0);
    send_beat(32'hA2, 1'b0, 1'b0, 0);
    send_beat(32'hA3, 1'b1, 1'b0, 0);
    @(negedge clock);
    check("drop_tready", 64'(s_tready), 64'd1);
    check("stall_tvalid", 64'(m_tvalid), 64'd1);
    check("stall_tdata", 64'(m_tdata), 64'hA0);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_tvalid", 64'(m_tvalid), 64'd0);
    check("mid_rst_tlast", 64'(m_tlast), 64'd0);
    check("mid_rst_tdata", 64'(m_tdata), 64'd0);
    check("mid_rst_tuser", 64'(m_tuser), 64'd0);
    check("mid_rst_tready", 64'(s_tready), 64'd0);
    check("mid_rst_tflag", 64'(trim_flag), 64'd0);
    check("mid_rst_tbeats", 64'(trim_beats), 64'd0);
    exp_q.delete();
    rdy_mode = 0;
    @(negedge clock);
    rst = 1'b0;
    @(posedge clock);
    #1;
    send_frame(3, 8, 1'b1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
